interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter N_CH, default 4: number of interrupt channels, range 1..16.
REQ-002 Parameter VEC_W, default 2: vector width; SHALL equal ceil(log2(N_CH)), minimum 1.
REQ-003 Parameter LEVEL_MODE, default {N_CH{1'b0}}: per-channel trigger mode, bit=1 level, bit=0 rising edge.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_interrupt_signal  input  N_CH  raw interrupt lines, bit 0 highest priority.
REQ-007 i_mask  input  N_CH  1 = channel blocked from raising a call; pending capture unaffected.
REQ-008 i_enable  input  1  fetch not stalled; gates only the IDLE->REQUEST transition.
REQ-009 i_ack  input  1  fetch has inserted the interrupt-call instruction for o_vector.
REQ-010 i_iret  input  1  handler return retired; ends in-service period.
REQ-011 o_interrupt_call  output  1  request to insert an interrupt-call instruction.
REQ-012 o_vector  output  VEC_W  channel index being requested or serviced.
REQ-013 o_pending  output  N_CH  current pending register.
REQ-014 o_in_service  output  1  a handler is executing.

Function
REQ-015 Per channel, a previous-sample register SHALL update from i_interrupt_signal every clock, independent of i_enable and FSM state.
REQ-016 Edge channel: rising edge (prev=0, current=1) at a clock edge SHALL set pending[i] on that same clock edge.
REQ-017 Level channel: pending[i] SHALL be set on every clock edge where the line is 1.
REQ-018 Pending SHALL be captured regardless of i_mask and of FSM state.
REQ-019 FSM states: IDLE, REQUEST, SERVICE; encoding implementation's choice.
REQ-020 IDLE: if i_enable=1 and (pending & ~i_mask) != 0 -> REQUEST; o_vector latched to lowest set index of (pending & ~i_mask).
REQ-021 o_interrupt_call SHALL be registered, 1 exactly while in REQUEST.
REQ-022 Latency: edge sampled at clock k -> o_interrupt_call=1 after clock k+1 (given i_enable=1, unmasked, IDLE).
REQ-023 REQUEST: o_vector and o_interrupt_call SHALL hold until i_ack=1; mask changes or i_enable=0 SHALL NOT retract the request.
REQ-024 REQUEST with i_ack=1: clear pending[o_vector], go to SERVICE.
REQ-025 Set beats clear: a new capture on channel o_vector in the i_ack cycle SHALL leave pending[o_vector]=1.
REQ-026 SERVICE: o_in_service=1, o_vector held, no new call raised (no nesting); pending continues to accumulate.
REQ-027 SERVICE with i_iret=1 -> IDLE; a qualifying pending channel SHALL raise a new call no earlier than the following clock.
REQ-028 i_ack outside REQUEST and i_iret outside SERVICE SHALL be ignored.
REQ-029 Multiple captures of one channel before acknowledge SHALL collapse to a single call.

Reset
REQ-030 i_reset=1 SHALL immediately and asynchronously force: state IDLE, pending=0, previous-sample registers=0, o_interrupt_call=0, o_vector=0, o_in_service=0.
REQ-031 Reset mid-REQUEST or mid-SERVICE SHALL abandon the request/service with no further call.
REQ-032 Since previous-sample registers reset to 0, a line held high across reset release SHALL register an edge on the first clock after release.

Verification (N_CH=4, LEVEL_MODE=0)
REQ-033 Line 2 rises at clock k, mask=0, enable=1 -> pending=4'b0100 after k; call=1, vector=2 after k+1; ack -> pending=0, in_service=1; iret -> IDLE.
REQ-034 Lines 1 and 3 rise together -> vector=1 first; after ack+iret, vector=3 called; each acknowledged exactly once.
REQ-035 Line 0 rises with mask=4'b0001 -> pending=4'b0001, no call; mask cleared -> call with vector=0 one clock later.
REQ-036 enable=0 in IDLE with pending -> no call; enable held 0 during REQUEST -> call stays 1 until ack.
REQ-037 Line 2 edge coincides with ack of vector 2 -> pending[2] stays 1; after iret a second call with vector=2.
REQ-038 Async reset asserted mid-SERVICE between clock edges -> all outputs 0 before next clock; line held high through release -> call two clocks after release.

Source files
------------

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: captures edge/level interrupts into a pending
// register and hands the lowest-numbered unmasked channel to fetch, one handler at a time.
module interrupt_controller #(
    parameter int unsigned         N_CH       = 4,
    parameter int unsigned         VEC_W      = 2,
    parameter logic [N_CH-1:0]     LEVEL_MODE = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_CH-1:0]    i_interrupt_signal,
    input  logic [N_CH-1:0]    i_mask,
    input  logic               i_enable,
    input  logic               i_ack,
    input  logic               i_iret,
    output logic               o_interrupt_call,
    output logic [VEC_W-1:0]   o_vector,
    output logic [N_CH-1:0]    o_pending,
    output logic               o_in_service
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_SERVICE
    } state_t;

    state_t            r_state;
    logic [N_CH-1:0]   r_prev;
    logic [N_CH-1:0]   r_pending;
    logic [N_CH-1:0]   w_capture;
    logic [N_CH-1:0]   w_eligible;
    logic [N_CH-1:0]   w_clear;
    logic [VEC_W-1:0]  w_first;

    // Lowest set index wins; bit 0 is highest priority.
    function automatic logic [VEC_W-1:0] lowest_index(input logic [N_CH-1:0] v);
        lowest_index = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = VEC_W'(i);
        end
    endfunction

    assign w_capture  = (i_interrupt_signal & ~r_prev) | (i_interrupt_signal & LEVEL_MODE);
    assign w_eligible = r_pending & ~i_mask;
    assign w_first    = lowest_index(w_eligible);
    assign o_pending  = r_pending;

    // Acknowledge clears the serviced channel; a same-cycle capture re-sets it below.
    always_comb begin
        w_clear = '0;
        if (r_state == S_REQUEST && i_ack) begin
            w_clear[o_vector] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_prev           <= '0;
            r_pending        <= '0;
            o_interrupt_call <= 1'b0;
            o_vector         <= '0;
            o_in_service     <= 1'b0;
        end else begin
            r_prev    <= i_interrupt_signal;
            r_pending <= (r_pending & ~w_clear) | w_capture;
            case (r_state)
                S_IDLE: begin
                    if (i_enable && (w_eligible != '0)) begin
                        r_state          <= S_REQUEST;
                        o_interrupt_call <= 1'b1;
                        o_vector         <= w_first;
                    end
                end
                S_REQUEST: begin
                    if (i_ack) begin
                        r_state          <= S_SERVICE;
                        o_interrupt_call <= 1'b0;
                        o_in_service     <= 1'b1;
                    end
                end
                S_SERVICE: begin
                    if (i_iret) begin
                        r_state      <= S_IDLE;
                        o_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    o_interrupt_call <= 1'b0;
                    o_in_service     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a behavioural model predicts the
// outputs after every clock; a separate monitor compares them on the falling edge.
module tb_interrupt_controller;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned VEC_W = 2;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic [N_CH-1:0]   i_interrupt_signal = '0;
    logic [N_CH-1:0]   i_mask = '0;
    logic              i_enable = 1'b0;
    logic              i_ack = 1'b0;
    logic              i_iret = 1'b0;
    logic              o_interrupt_call;
    logic [VEC_W-1:0]  o_vector;
    logic [N_CH-1:0]   o_pending;
    logic              o_in_service;

    interrupt_controller #(.N_CH(N_CH), .VEC_W(VEC_W), .LEVEL_MODE(4'b0000)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_interrupt_signal(i_interrupt_signal),
        .i_mask(i_mask), .i_enable(i_enable), .i_ack(i_ack), .i_iret(i_iret),
        .o_interrupt_call(o_interrupt_call), .o_vector(o_vector),
        .o_pending(o_pending), .o_in_service(o_in_service)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int call;
        int vec;
        int pend;
        int svc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: which handler phase we are in, counted as plain integers.
    bit   m_line_prev[N_CH];
    bit   m_pend[N_CH];
    bit   m_requesting;
    bit   m_servicing;
    int   m_vec;
    int   acks_seen[N_CH];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pend_word();
        int w = 0;
        for (int i = 0; i < N_CH; i++) if (m_pend[i]) w += (1 << i);
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_line_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_requesting = 1'b0;
        m_servicing  = 1'b0;
        m_vec        = 0;
    endtask

    // One clock of behaviour given the inputs that were present at the edge.
    task automatic model_clock(input logic [N_CH-1:0] line, input logic [N_CH-1:0] mask,
                               input logic en, input logic ack, input logic iret);
        bit fresh[N_CH];
        int pick = -1;
        for (int i = 0; i < N_CH; i++) fresh[i] = line[i] && !m_line_prev[i];
        for (int i = N_CH - 1; i >= 0; i--) if (m_pend[i] && !mask[i]) pick = i;
        if (m_requesting) begin
            if (ack) begin
                m_pend[m_vec] = 1'b0;
                acks_seen[m_vec]++;
                m_requesting = 1'b0;
                m_servicing  = 1'b1;
            end
        end else if (m_servicing) begin
            if (iret) m_servicing = 1'b0;
        end else if (en && pick >= 0) begin
            m_requesting = 1'b1;
            m_vec = pick;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (fresh[i]) m_pend[i] = 1'b1;
            m_line_prev[i] = line[i];
        end
    endtask

    task automatic step(input logic [N_CH-1:0] line, input logic [N_CH-1:0] mask,
                        input logic en, input logic ack, input logic iret);
        exp_t e;
        i_interrupt_signal = line;
        i_mask   = mask;
        i_enable = en;
        i_ack    = ack;
        i_iret   = iret;
        @(posedge i_clk);
        #1;
        model_clock(line, mask, en, ack, iret);
        e.call = m_requesting ? 1 : 0;
        e.vec  = m_vec;
        e.pend = pend_word();
        e.svc  = m_servicing ? 1 : 0;
        exp_q.push_back(e);
        @(negedge i_clk);
    endtask

    // Reset asserted between edges; outputs must clear before any clock arrives.
    task automatic async_reset(input logic [N_CH-1:0] line_hold);
        #2;
        i_interrupt_signal = line_hold;
        i_reset = 1'b1;
        #1;
        check("async_call", int'(o_interrupt_call), 0);
        check("async_vector", int'(o_vector), 0);
        check("async_pending", int'(o_pending), 0);
        check("async_in_service", int'(o_in_service), 0);
        model_reset();
        @(negedge i_clk);
        #2;
        i_reset = 1'b0;
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("call", int'(o_interrupt_call), e.call);
            check("vector", int'(o_vector), e.vec);
            check("pending", int'(o_pending), e.pend);
            check("in_service", int'(o_in_service), e.svc);
        end
    end

    initial begin
        logic [N_CH-1:0] line;
        model_reset();
        for (int i = 0; i < N_CH; i++) acks_seen[i] = 0;
        repeat (2) @(negedge i_clk);
        check("reset_pending", int'(o_pending), 0);
        check("reset_call", int'(o_interrupt_call), 0);
        #2 i_reset = 1'b0;
        @(negedge i_clk);

        // Single edge on line 2: capture, call, ack, iret.
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0100, 4'b0000, 1, 0, 0);
        step(4'b0100, 4'b0000, 1, 0, 0);
        step(4'b0100, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);
        step(4'b0000, 4'b0000, 1, 0, 1);

        // Lines 1 and 3 together: priority order, each acknowledged once.
        step(4'b1010, 4'b0000, 1, 0, 0);
        step(4'b1010, 4'b0000, 1, 0, 0);
        step(4'b1010, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);
        step(4'b0000, 4'b0000, 1, 0, 0);
        check("ack_count_ch1", acks_seen[1], 1);
        check("ack_count_ch3", acks_seen[3], 1);

        // Masked line 0, then unmasked.
        step(4'b0001, 4'b0001, 1, 0, 0);
        step(4'b0001, 4'b0001, 1, 0, 0);
        step(4'b0001, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0001, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);

        // Enable low in IDLE blocks the call; low during REQUEST does not retract it.
        step(4'b0010, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b1111, 0, 0, 1);
        step(4'b0000, 4'b1111, 0, 0, 0);
        step(4'b0000, 4'b0000, 0, 1, 0);
        step(4'b0000, 4'b0000, 0, 0, 1);

        // Fresh edge on line 2 in its own ack cycle keeps it pending.
        step(4'b0100, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0100, 4'b0000, 1, 1, 0);
        step(4'b0100, 4'b0000, 1, 0, 0);
        step(4'b0100, 4'b0000, 1, 0, 1);
        step(4'b0100, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("ack_count_ch2", acks_seen[2], 3);

        // Reset mid-SERVICE with line 0 held high through release.
        step(4'b1000, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 1, 0);
        async_reset(4'b0001);
        step(4'b0001, 4'b0000, 1, 0, 0);
        step(4'b0001, 4'b0000, 1, 0, 0);
        step(4'b0001, 4'b0000, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);

        // Randomised traffic, including stray ack/iret outside their phases.
        line = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N_CH; b++)
                if ($urandom_range(0, 5) == 0) line[b] = ~line[b];
            step(line,
                 ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0);
            if (n == 300) async_reset(line);
        end

        @(posedge i_clk);
        @(negedge i_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
